// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab blocks: FSM state encoding and
// the default datapath width.
package arith_pkg;

  localparam int ARITH_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle of the bit-serial adder/subtractor.
// Handshake: start is accepted only on a cycle where ready=1; done is a
// one-cycle strobe and Result/Carry/Overflow stay stable until the next done.
interface serial_add_sub_if
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             Carry;
  logic             Overflow;

  modport master (
    output start, sub, A, B,
    input  ready, busy, done, Result, Carry, Overflow
  );

  modport slave (
    input  start, sub, A, B,
    output ready, busy, done, Result, Carry, Overflow
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder, reused by the serial datapath as its per-bit slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full_adder slice processes the
// operands LSB first over WIDTH RUN cycles, then results are published on done.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_add_sub_if.slave         bus,
  output state_t                  dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             c_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             ovf_q;
  logic             s;
  logic             c;
  logic             last_bit;

  full_adder u_slice (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (c_reg),
    .Sum  (s),
    .Carry(c)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_RUN;
      ST_RUN:  if (last_bit)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      c_reg    <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with sub.
            a_sh  <= bus.A;
            b_sh  <= bus.B ^ {WIDTH{bus.sub}};
            c_reg <= bus.sub;
            cnt   <= '0;
            r_sh  <= '0;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= {s, r_sh[WIDTH-1:1]};
          c_reg <= c;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the MSB, c_reg is the carry into the MSB and c the carry out,
            // so the outputs are captured straight from the slice on this edge.
            result_q <= {s, r_sh[WIDTH-1:1]};
            carry_q  <= c;
            ovf_q    <= c_reg ^ c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state == ST_IDLE);
  assign bus.busy     = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);
  assign bus.Result   = result_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed vectors, randomized ops
// against an arithmetic reference model, and multi-cycle corner sequences.
module tb_serial_add_sub;
  import arith_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } vec_t;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  serial_add_sub_if #(.WIDTH(W)) bus ();

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             checks;
  int             errors;
  int             done_count;
  logic [W+1:0]   exp_q[$];
  logic [W+1:0]   hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned/signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int ua, ub, sa, sb, ur, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ur = ua + ub;
      c  = (ur >= (1 << W));
      sr = sa + sb;
    end else begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    v = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    return {ur[W-1:0], c, v};
  endfunction

  // scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (bus.done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("result", 32'(bus.Result), 32'(e[W+1:2]));
        check("carry", 32'(bus.Carry), 32'(e[1]));
        check("overflow", 32'(bus.Overflow), 32'(e[0]));
        hold = e;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W+1:0] e);
    int lat, nbusy;
    bit got, held_ok;
    wait_ready();
    exp_q.push_back(e);
    bus.A = a;
    bus.B = b;
    bus.sub = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = W'($urandom);
    bus.B = W'($urandom);
    bus.sub = 1'($urandom);
    lat = 1;
    nbusy = 0;
    got = 0;
    held_ok = 1;
    while (lat < 4 * W) begin
      if (bus.done) begin
        got = 1;
        break;
      end
      if (bus.busy) begin
        nbusy++;
        if ({bus.Result, bus.Carry, bus.Overflow} !== hold) held_ok = 0;
      end
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(got), 32'd1);
    check("latency", 32'(lat), 32'(W + 1));
    check("busy_cycles", 32'(nbusy), 32'(W));
    check("outputs_held", 32'(held_ok), 32'd1);
    @(negedge clk);
    check("done_pulse_one_cycle", 32'(bus.done), 32'd0);
    check("ready_after_done", 32'(bus.ready), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.Result), 32'd0);
    check({tag, "_carry"}, 32'(bus.Carry), 32'd0);
    check({tag, "_overflow"}, 32'(bus.Overflow), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  vec_t vecs[7];

  initial begin
    int d0, t_first, t_second, n;
    logic [W-1:0] ra, rb;
    logic rs;

    vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    checks = 0;
    errors = 0;
    done_count = 0;
    hold = '0;
    bus.start = 1'b0;
    bus.sub = 1'b0;
    bus.A = '0;
    bus.B = '0;

    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");

    // directed vectors
    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, {vecs[i].r, vecs[i].c, vecs[i].v});

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(0, 3) == 0 ? 32'hFF : $urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, model(ra, rb, rs));
    end

    // start while busy is ignored and late operand changes have no effect
    wait_ready();
    d0 = done_count;
    exp_q.push_back({8'h30, 1'b0, 1'b0});
    bus.A = 8'h10;
    bus.B = 8'h20;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.A = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3 * W) @(negedge clk);
    check("busy_start_single_done", 32'(done_count - d0), 32'd1);
    check("busy_start_idle", 32'(dbg_state), 32'(ST_IDLE));

    // start held high: back-to-back operations spaced by WIDTH+2 cycles
    wait_ready();
    d0 = done_count;
    t_first = -1;
    t_second = -1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    exp_q.push_back(model(8'h12, 8'h34, 1'b0));
    bus.A = 8'h12;
    bus.B = 8'h34;
    bus.sub = 1'b0;
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 6 * W; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        if (t_first < 0) t_first = cyc;
        else begin
          t_second = cyc;
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    repeat (2 * W) @(negedge clk);
    check("b2b_two_dones", 32'(done_count - d0), 32'd2);
    check("b2b_spacing", 32'(t_second - t_first), 32'(W + 2));

    // reset in the middle of RUN aborts without a done
    wait_ready();
    bus.A = 8'hC3;
    bus.B = 8'h5A;
    bus.sub = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_run_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold = '0;
    check_reset_state("mid_reset");
    d0 = done_count;
    n = 0;
    repeat (2 * W) begin
      @(negedge clk);
      n++;
    end
    check("abort_no_done", 32'(done_count - d0), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, {8'h02, 1'b0, 1'b0});

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
